phase_sched: RTL and testbench
==============================

// Module: phase_sched
// PURPOSE
//  Controller that drives the decade time-base counter (en in, carry out, period 10 clk).
//  Runs a programmable sequence of PHASES phases. Each phase lasts dur[k] counter periods.
//  Raises a tick at each phase boundary and a done pulse at the end.
//  Sits between the user-facing start/pause/stop controls and the time-base counter.
// PARAMETERS
//  PHASES  4   number of phases in a sequence (>=2)
//  DW      4   width of one phase duration, in counter periods
//  PW      $clog2(PHASES)   localparam, width of phase_o
// PORTS
//  clk           in   1          single clock, all logic on posedge
//  rst_n         in   1          asynchronous, active-low reset
//  start_i       in   1          start a sequence (sampled only in IDLE)
//  pause_i       in   1          level; freezes the sequence while high
//  stop_i        in   1          abort; returns to IDLE
//  dur_i         in   PHASES*DW  phase k duration = dur_i[k*DW +: DW]
//  cnt_carry_i   in   1          carry_o of the time-base counter
//  cnt_en_o      out  1          enable to the counter
//  cnt_rst_o     out  1          active-high reset to the counter, 1-cycle pulse
//  phase_o       out  PW         current phase index
//  busy_o        out  1          high in ARM, RUN and HOLD
//  phase_tick_o  out  1          1-cycle pulse at each phase end
//  done_o        out  1          1-cycle pulse when the sequence completes
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset: state=IDLE; all outputs 0, phase_o=0; carry_q=0; rem=0; shadow dur=0.
//  - States: IDLE, ARM, RUN, HOLD, DONE.
//  - IDLE: start_i=1 and stop_i=0 -> latch dur_i into shadow regs, go to ARM.
//      dur_i changes after this latch are ignored until the next start.
//  - ARM (1 cycle): cnt_rst_o=1, cnt_en_o=0, phase=0, rem=dur[0]; then go to RUN.
//  - RUN: cnt_en_o=1. edge = cnt_carry_i & ~carry_q, where carry_q is cnt_carry_i delayed 1 clk.
//      On edge with rem>1: rem=rem-1.
//      On edge with rem<=1: pulse phase_tick_o; then either
//        phase<PHASES-1 -> phase=phase+1, rem=dur[phase+1], stay in RUN (no counter re-arm), or
//        last phase -> go to DONE.
//  - Duration 0 is treated as 1 period. Phase k therefore lasts max(dur[k],1) carry edges.
//  - HOLD: entered from RUN when pause_i=1; cnt_en_o=0. Returns to RUN when pause_i=0.
//      carry_q keeps tracking in HOLD, so a carry held by the frozen counter is never recounted.
//      rem and phase are unchanged across HOLD.
//  - DONE (1 cycle): done_o=1, cnt_en_o=0, busy_o=0; then go to IDLE.
//      phase_o holds PHASES-1 until the next ARM.
//  - stop_i=1 in ARM/RUN/HOLD: next state IDLE; cnt_en_o=0; cnt_rst_o pulses 1 cycle;
//      no tick and no done.
//  - Priority in the same cycle: stop_i > pause_i > carry edge. start_i is ignored outside IDLE.
//  - A carry edge in the same cycle as pause_i is dropped. It is not recounted after HOLD
//      (carry_q already high).
//  - rst_n low mid-sequence: immediate return to reset values; a pending tick or done is lost.
//  - rem is DW bits wide. Arithmetic never wraps, because decrement happens only for rem>1.
// CONFIGURATION
//  PHASE_SCHED_LOOP_EN defined:
//    - After the last phase, go to phase 0 with rem=dur[0] and stay in RUN.
//    - done_o pulses on each wrap.
//    - The sequence runs until stop_i.
//  PHASE_SCHED_LOOP_EN undefined: the last phase goes to DONE, then IDLE, as described above.
// TESTING
//  Bench uses a cycle-accurate decade counter model driven by cnt_en_o / cnt_rst_o.
//  1 Reset: rst_n=0 mid-RUN -> all outputs 0 immediately; IDLE after release;
//    start_i is accepted 1 cycle later.
//  2 dur={4,3,2,1} (phase3..0): start -> cnt_rst_o 1 cycle, then ticks after
//    1,2,3,4 carry edges (10,20,30,40 clk apart); phase_o 0->1->2->3; done_o 1 cycle later.
//  3 dur[1]=0 -> phase 1 lasts exactly 1 carry edge (10 clk).
//  4 pause_i high 25 clk in phase 1 -> cnt_en_o=0 throughout; phase 1 ends 25 clk later
//    than in scenario 2; no extra tick.
//  5 stop_i asserted in the same cycle as a carry edge in phase 2 -> IDLE, no tick, no done,
//    cnt_rst_o 1 pulse; start_i ignored while busy_o=1.
//  6 LOOP_EN build, dur all 1 -> phase_o 0,1,2,3,0,... every 10 clk; done_o on each wrap;
//    stop_i ends the run.

Source files
------------

// File: rtl/phase_sched.sv
// Phase sequencer for a decade time-base counter: runs PHASES phases of dur[k] counter periods each.
// Build option PHASE_SCHED_LOOP_EN: wrap to phase 0 after the last phase instead of finishing.
module phase_sched #(
    parameter int PHASES = 4,
    parameter int DW     = 4,
    localparam int PW    = $clog2(PHASES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 pause_i,
    input  logic                 stop_i,
    input  logic [PHASES*DW-1:0] dur_i,
    input  logic                 cnt_carry_i,
    output logic                 cnt_en_o,
    output logic                 cnt_rst_o,
    output logic [PW-1:0]        phase_o,
    output logic                 busy_o,
    output logic                 phase_tick_o,
    output logic                 done_o,
    output logic [2:0]           dbg_state_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]           state_q, state_d;
    logic                 carry_q;
    logic [DW-1:0]        rem_q, rem_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [PHASES*DW-1:0] dur_q, dur_d;
    logic                 cnt_en_q, cnt_en_d;
    logic                 cnt_rst_q, cnt_rst_d;
    logic                 busy_q, busy_d;
    logic                 tick_q, tick_d;
    logic                 done_q, done_d;
    logic                 last_q, last_d;

    logic                 carry_edge;
    logic                 phase_last;
    logic [PW-1:0]        phase_nxt;
    logic [DW-1:0]        dur_nxt;
    logic                 stop_busy;

    // Only the rising edge of carry counts; a carry held by a frozen counter is seen once.
    assign carry_edge = cnt_carry_i & ~carry_q;
    assign phase_last = (phase_q == PW'(PHASES - 1));
    assign phase_nxt  = phase_last ? '0 : phase_q + 1'b1;
    assign dur_nxt    = dur_q[int'(phase_nxt)*DW +: DW];
    assign stop_busy  = stop_i & ((state_q == S_ARM) | (state_q == S_RUN) | (state_q == S_HOLD));

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        phase_d   = phase_q;
        dur_d     = dur_q;
        cnt_rst_d = 1'b0;
        tick_d    = 1'b0;
        last_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    dur_d     = dur_i;
                    phase_d   = '0;
                    rem_d     = dur_i[DW-1:0];
                    cnt_rst_d = 1'b1;
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
                if (stop_i) begin
                    cnt_rst_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop_i) begin
                    cnt_rst_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (pause_i) begin
                    state_d = S_HOLD;
                end else if (carry_edge) begin
                    // rem of 0 or 1 both mean "this is the final period of the phase".
                    if (rem_q > DW'(1)) begin
                        rem_d = rem_q - 1'b1;
                    end else begin
                        tick_d = 1'b1;
                        if (!phase_last) begin
                            phase_d = phase_nxt;
                            rem_d   = dur_nxt;
                        end else begin
                            last_d = 1'b1;
`ifdef PHASE_SCHED_LOOP_EN
                            phase_d = '0;
                            rem_d   = dur_q[DW-1:0];
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end
            S_HOLD: begin
                if (stop_i) begin
                    cnt_rst_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (!pause_i) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cnt_en_d = (state_d == S_RUN);
    assign busy_d   = (state_d == S_ARM) | (state_d == S_RUN) | (state_d == S_HOLD);
    // done follows the final tick by one cycle; an abort in that cycle suppresses it.
    assign done_d   = last_q & ~stop_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            carry_q   <= 1'b0;
            rem_q     <= '0;
            phase_q   <= '0;
            dur_q     <= '0;
            cnt_en_q  <= 1'b0;
            cnt_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            carry_q   <= cnt_carry_i;
            rem_q     <= rem_d;
            phase_q   <= phase_d;
            dur_q     <= dur_d;
            cnt_en_q  <= cnt_en_d;
            cnt_rst_q <= cnt_rst_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            last_q    <= last_d;
        end
    end

    assign cnt_en_o     = cnt_en_q;
    assign cnt_rst_o    = cnt_rst_q;
    assign phase_o      = phase_q;
    assign busy_o       = busy_q;
    assign phase_tick_o = tick_q;
    assign done_o       = done_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_phase_sched.sv
// Bench for phase_sched: decade counter model, table of sequences, scoreboard of event cycles.
module tb_phase_sched;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        pause_i;
  logic        stop_i;
  logic [15:0] dur_i;
  logic        cnt_carry;
  logic        cnt_en_o;
  logic        cnt_rst_o;
  logic [1:0]  phase_o;
  logic        busy_o;
  logic        phase_tick_o;
  logic        done_o;
  logic [2:0]  dbg_state_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // expected event cycles; tick entries carry the expected phase in the low nibble
  logic [W-1:0] exp_tick_q[$];
  logic [W-1:0] exp_done_q[$];
  logic [W-1:0] exp_rst_q[$];

  phase_sched #(.PHASES(4), .DW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .pause_i      (pause_i),
    .stop_i       (stop_i),
    .dur_i        (dur_i),
    .cnt_carry_i  (cnt_carry),
    .cnt_en_o     (cnt_en_o),
    .cnt_rst_o    (cnt_rst_o),
    .phase_o      (phase_o),
    .busy_o       (busy_o),
    .phase_tick_o (phase_tick_o),
    .done_o       (done_o),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // decade counter model: carry while count is 9
  logic [3:0] cnt_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else if (cnt_rst_o) cnt_q <= 4'd0;
    else if (cnt_en_o) cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
  end
  assign cnt_carry = (cnt_q == 4'd9);

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s unexpected event at cyc %0d phase=%0d", name, cyc, phase_o);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (phase_tick_o) begin
        if (exp_tick_q.size() == 0) unexpected("tick");
        else check("tick", W'(cyc * 16 + int'(phase_o)), exp_tick_q.pop_front());
      end
      if (done_o) begin
        if (exp_done_q.size() == 0) unexpected("done");
        else check("done", W'(cyc), exp_done_q.pop_front());
      end
      if (cnt_rst_o) begin
        if (exp_rst_q.size() == 0) unexpected("cnt_rst");
        else check("cnt_rst", W'(cyc), exp_rst_q.pop_front());
      end
    end
  end

  // drive start and push expected events; npush limits how many ticks are expected
  task automatic start_seq(input logic [15:0] d, input int plen, input int npush,
                           output int c, output int tl);
    int cum, eff, t, ph;
    @(negedge clk);
    dur_i = d;
    start_i = 1'b1;
    c = cyc;
    exp_rst_q.push_back(W'(c + 1));
    cum = 0;
    t = 0;
    for (int k = 0; k < 4; k++) begin
      eff = int'(d[k*4 +: 4]);
      if (eff == 0) eff = 1;
      cum += eff;
      t = c + 2 + 10 * cum + ((k >= 1) ? plen : 0);
      ph = (k < 3) ? k + 1 : 3;
      if (k < npush) exp_tick_q.push_back(W'(t * 16 + ph));
    end
    if (npush == 4) exp_done_q.push_back(W'(t + 1));
    tl = t;
    @(negedge clk);
    start_i = 1'b0;
    dur_i = 16'($urandom);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic run_vec(input logic [15:0] d, input int plen);
    int c, tl, p, en_hi, e0;
    start_seq(d, plen, 4, c, tl);
    if (plen > 0) begin
      e0 = (d[3:0] == 4'd0) ? 1 : int'(d[3:0]);
      p = c + 2 + 10 * e0 + 3;
      wait_cyc(p);
      pause_i = 1'b1;
      en_hi = 0;
      for (int i = 0; i < plen; i++) begin
        @(negedge clk);
        if (cnt_en_o) en_hi++;
      end
      pause_i = 1'b0;
      check("pause_en_low", W'(en_hi), '0);
    end
    wait_cyc(tl + 3);
    check("drained", W'(exp_tick_q.size() + exp_done_q.size() + exp_rst_q.size()), '0);
    check("idle_phase_hold", W'({busy_o, phase_o, dbg_state_o}), W'({1'b0, 2'd3, 3'd0}));
  endtask

  typedef struct {
    logic [15:0] dur;
    int          plen;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c, tl;
    rst_n = 1'b0;
    start_i = 1'b0;
    pause_i = 1'b0;
    stop_i = 1'b0;
    dur_i = 16'h0;
    vecs[0] = '{16'h4321, 0};
    vecs[1] = '{16'h1102, 0};
    vecs[2] = '{16'h4321, 25};
    for (int i = 3; i < 6; i++) begin
      vecs[i].dur = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      vecs[i].plen = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 30)) : 0;
    end

    repeat (2) @(negedge clk);
    check("reset_state", W'({cnt_en_o, cnt_rst_o, phase_o, busy_o, phase_tick_o, done_o, dbg_state_o}), '0);
    rst_n = 1'b1;

`ifdef PHASE_SCHED_LOOP_EN
    @(negedge clk);
    dur_i = 16'h1111;
    start_i = 1'b1;
    c = cyc;
    exp_rst_q.push_back(W'(c + 1));
    for (int k = 0; k < 8; k++) begin
      exp_tick_q.push_back(W'((c + 2 + 10 * (k + 1)) * 16 + ((k + 1) % 4)));
      if (k % 4 == 3) exp_done_q.push_back(W'(c + 3 + 10 * (k + 1)));
    end
    @(negedge clk);
    start_i = 1'b0;
    wait_cyc(c + 85);
    check("loop_busy", W'({busy_o, phase_o}), W'({1'b1, 2'd0}));
    stop_i = 1'b1;
    exp_rst_q.push_back(W'(cyc + 1));
    @(negedge clk);
    stop_i = 1'b0;
    wait_cyc(c + 120);
    check("loop_drained", W'(exp_tick_q.size() + exp_done_q.size() + exp_rst_q.size()), '0);
    check("loop_idle", W'({busy_o, dbg_state_o}), '0);
`else
    for (int i = 0; i < 6; i++) run_vec(vecs[i].dur, vecs[i].plen);

    // stop on the carry edge that would end phase 2; start while busy is ignored
    start_seq(16'h4321, 0, 2, c, tl);
    wait_cyc(c + 20);
    check("busy_run", W'({busy_o, phase_o}), W'({1'b1, 2'd1}));
    start_i = 1'b1;
    dur_i = 16'h0;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    wait_cyc(c + 61);
    check("stop_carry_phase", W'({cnt_carry, phase_o}), W'({1'b1, 2'd2}));
    stop_i = 1'b1;
    exp_rst_q.push_back(W'(c + 62));
    @(negedge clk);
    stop_i = 1'b0;
    check("stop_idle", W'({busy_o, cnt_en_o, dbg_state_o}), '0);
    wait_cyc(c + 90);
    check("stop_drained", W'(exp_tick_q.size() + exp_done_q.size() + exp_rst_q.size()), '0);

    // asynchronous reset mid-run, then a start one cycle after release
    start_seq(16'h4321, 0, 2, c, tl);
    wait_cyc(c + 25);
    rst_n = 1'b0;
    #1;
    exp_tick_q.delete();
    exp_done_q.delete();
    exp_rst_q.delete();
    check("reset_mid", W'({cnt_en_o, cnt_rst_o, phase_o, busy_o, phase_tick_o, done_o, dbg_state_o}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(16'h2113, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
